lsu_riscv: RTL

Load-store unit that consumes the memory-request fields produced by the instruction decoder (`mem_req`, `mem_we`, `mem_size`) plus the ALU-computed address and rs2 data, and drives the data-memory request/grant/response interface. It stalls the core until each access completes. For loads, it returns a sign- or zero-extended value. For stores, it aligns the data and generates byte enables. It sits between the execute stage and the data memory and is the memory-side counterpart of the decoder's memory controls.

---
 rtl/lsu_riscv.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_riscv.sv
// Load-store unit: turns decoder memory controls into a req/gnt/rvalid data-memory access
// and stalls the core until it completes. Optional macro: LSU_MISALIGN_CHECK_EN.
`ifndef LDST_B
`define LDST_B  3'd0
`endif
`ifndef LDST_H
`define LDST_H  3'd1
`endif
`ifndef LDST_W
`define LDST_W  3'd2
`endif
`ifndef LDST_BU
`define LDST_BU 3'd4
`endif
`ifndef LDST_HU
`define LDST_HU 3'd5
`endif

module lsu_riscv (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_misalign_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]  state_reg;
    logic [29:0] addr_reg;
    logic        we_reg;
    logic [3:0]  be_reg;
    logic [31:0] wdata_reg;
    logic [2:0]  size_reg;
    logic [1:0]  off_reg;
    logic [31:0] result_reg;

    logic        size_valid;
    logic        misaligned;
    logic        accept;
    logic        complete;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_ext;

    logic [3:0]  be_byte;
    logic [3:0]  be_half;
    logic [7:0]  rbyte [4];

    // Per-lane enables for byte and halfword accesses, and the read-data byte lanes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign be_byte[gi] = (lsu_addr_i[1:0] == 2'(gi));
            assign be_half[gi] = (lsu_addr_i[1] == 1'(gi / 2));
            assign rbyte[gi]   = data_rdata_i[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        size_valid = 1'b0;
        case (lsu_size_i)
            `LDST_B, `LDST_H, `LDST_W, `LDST_BU, `LDST_HU: size_valid = 1'b1;
            default:                                        size_valid = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        case (lsu_size_i)
            `LDST_H, `LDST_HU: misaligned = lsu_addr_i[0];
            `LDST_W:           misaligned = (lsu_addr_i[1:0] != 2'b00);
            default:           misaligned = 1'b0;
        endcase
    end
`else
    // Without the check, address bits below the access size are simply dropped.
    assign misaligned = 1'b0;
`endif

    always_comb begin
        be_next    = 4'b0000;
        wdata_next = lsu_data_i;
        case (lsu_size_i)
            `LDST_B, `LDST_BU: begin
                be_next    = be_byte;
                wdata_next = {4{lsu_data_i[7:0]}};
            end
            `LDST_H, `LDST_HU: begin
                be_next    = be_half;
                wdata_next = {2{lsu_data_i[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = lsu_data_i;
            end
        endcase
    end

    always_comb begin
        logic [7:0]  sel_byte;
        logic [15:0] sel_half;
        sel_byte = rbyte[off_reg];
        sel_half = off_reg[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        load_ext = data_rdata_i;
        case (size_reg)
            `LDST_B:  load_ext = {{24{sel_byte[7]}}, sel_byte};
            `LDST_BU: load_ext = {24'd0, sel_byte};
            `LDST_H:  load_ext = {{16{sel_half[15]}}, sel_half};
            `LDST_HU: load_ext = {16'd0, sel_half};
            default:  load_ext = data_rdata_i;
        endcase
    end

    assign accept   = (state_reg == IDLE) & lsu_req_i & size_valid & ~misaligned;
    assign complete = (state_reg == WAIT) & data_rvalid_i;

    // Leaving WAIT on completion is what keeps a held request from being re-issued:
    // the core advances on that edge, so a request seen in IDLE afterwards is new.
    always_comb begin
        if (state_reg == IDLE) begin
            lsu_stall_req_o = lsu_req_i & size_valid & ~misaligned;
        end else begin
            lsu_stall_req_o = lsu_req_i & ~complete;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_reg  <= IDLE;
            addr_reg   <= 30'd0;
            we_reg     <= 1'b0;
            be_reg     <= 4'b0000;
            wdata_reg  <= 32'd0;
            size_reg   <= 3'd0;
            off_reg    <= 2'd0;
            result_reg <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg  <= lsu_addr_i[31:2];
                        we_reg    <= lsu_we_i;
                        be_reg    <= be_next;
                        wdata_reg <= wdata_next;
                        size_reg  <= lsu_size_i;
                        off_reg   <= lsu_addr_i[1:0];
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (data_gnt_i) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (data_rvalid_i) begin
                        state_reg <= IDLE;
                        if (!we_reg) begin
                            result_reg <= load_ext;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic misalign_reg;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= (state_reg == IDLE) & lsu_req_i & size_valid & misaligned;
        end
    end

    assign lsu_misalign_o = misalign_reg;
`else
    assign lsu_misalign_o = 1'b0;
`endif

    assign data_req_o   = (state_reg == REQ);
    assign data_we_o    = we_reg;
    assign data_be_o    = be_reg;
    assign data_addr_o  = {addr_reg, 2'b00};
    assign data_wdata_o = wdata_reg;
    assign lsu_data_o   = complete ? load_ext : result_reg;

endmodule
